// File: rtl/seq_muldiv.sv
// Multi-cycle unsigned multiply/divide sequencer: one shared N+1-bit add/subtract
// unit, one shift-and-add or restoring shift-and-subtract step per clock.
module seq_muldiv #(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic         op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         z,
    output logic         n,
    output logic         dbz
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_r, state_s;
    logic [CW-1:0]  cnt_r, cnt_s;
    logic [N:0]     acc_r, acc_s;
    logic [N-1:0]   mq_r, mq_s;
    logic [N-1:0]   b_r, b_s;
    logic           op_r, op_s;
    logic [N-1:0]   hi_r, hi_s, lo_r, lo_s;
    logic           z_r, z_s, n_r, n_s, dbz_r, dbz_s;
    logic           busy_r, done_r;

    logic [N:0]     add_x_s, add_y_s;
    logic           add_cin_s;
    logic [N+1:0]   add_sum_s;
    logic [N:0]     rem_sh_s;
    logic [N-1:0]   mq_sh_s;
    logic [N:0]     acc_tmp_s;
    logic [N:0]     step_acc_s;
    logic [N-1:0]   step_mq_s;

    // One iteration of the datapath; acc_r doubles as the divide remainder.
    always_comb begin
        rem_sh_s   = {acc_r[N-1:0], mq_r[N-1]};
        mq_sh_s    = {mq_r[N-2:0], 1'b0};
        acc_tmp_s  = acc_r;
        step_acc_s = acc_r;
        step_mq_s  = mq_r;
        // Subtraction is x + ~y + 1; bit N+1 of the sum is the "no borrow" flag.
        if (op_r) begin
            add_x_s   = rem_sh_s;
            add_y_s   = ~{1'b0, b_r};
            add_cin_s = 1'b1;
        end else begin
            add_x_s   = {1'b0, acc_r[N-1:0]};
            add_y_s   = {1'b0, b_r};
            add_cin_s = 1'b0;
        end
        add_sum_s = {1'b0, add_x_s} + {1'b0, add_y_s} + {{(N+1){1'b0}}, add_cin_s};
        if (op_r) begin
            if (add_sum_s[N+1]) begin
                step_acc_s = add_sum_s[N:0];
                step_mq_s  = {mq_r[N-2:0], 1'b1};
            end else begin
                step_acc_s = rem_sh_s;
                step_mq_s  = mq_sh_s;
            end
        end else begin
            if (mq_r[0]) begin
                acc_tmp_s = add_sum_s[N:0];
            end else begin
                acc_tmp_s = acc_r;
            end
            step_acc_s = {1'b0, acc_tmp_s[N:1]};
            step_mq_s  = {acc_tmp_s[0], mq_r[N-1:1]};
        end
    end

    // Next-state and next-register values for the sequencer.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        acc_s   = acc_r;
        mq_s    = mq_r;
        b_s     = b_r;
        op_s    = op_r;
        hi_s    = hi_r;
        lo_s    = lo_r;
        z_s     = z_r;
        n_s     = n_r;
        dbz_s   = dbz_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    op_s  = op;
                    b_s   = b;
                    dbz_s = 1'b0;
                    if (op && (b == {N{1'b0}})) begin
                        state_s = DONE;
                        hi_s    = a;
                        lo_s    = {N{1'b1}};
                        dbz_s   = 1'b1;
                        z_s     = 1'b0;
                        n_s     = a[N-1];
                    end else begin
                        state_s = CALC;
                        acc_s   = {(N+1){1'b0}};
                        mq_s    = a;
                        cnt_s   = CW'(N);
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                acc_s = step_acc_s;
                mq_s  = step_mq_s;
                cnt_s = cnt_r - CW'(1);
                if (cnt_r == CW'(1)) begin
                    state_s = DONE;
                    hi_s    = step_acc_s[N-1:0];
                    lo_s    = step_mq_s;
                    z_s     = ({step_acc_s[N-1:0], step_mq_s} == {(2*N){1'b0}});
                    n_s     = step_acc_s[N-1];
                end else begin
                    state_s = CALC;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, working and result registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            acc_r   <= {(N+1){1'b0}};
            mq_r    <= {N{1'b0}};
            b_r     <= {N{1'b0}};
            op_r    <= 1'b0;
            hi_r    <= {N{1'b0}};
            lo_r    <= {N{1'b0}};
            z_r     <= 1'b0;
            n_r     <= 1'b0;
            dbz_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            acc_r   <= acc_s;
            mq_r    <= mq_s;
            b_r     <= b_s;
            op_r    <= op_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
            z_r     <= z_s;
            n_r     <= n_s;
            dbz_r   <= dbz_s;
            busy_r  <= (state_s == CALC);
            done_r  <= (state_s == DONE);
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;
    assign z    = z_r;
    assign n    = n_r;
    assign dbz  = dbz_r;

endmodule

// File: tb/tb_seq_muldiv.sv
// Self-checking bench for seq_muldiv: directed cases from the test plan plus
// randomized operations compared against plain-arithmetic reference results.
module tb_seq_muldiv;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        z;
    logic        n;
    logic        dbz;

    int n_checks = 0;
    int n_pass   = 0;

    seq_muldiv #(.N(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .z       (z),
        .n       (n),
        .dbz     (dbz)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {hi, lo} as defined by the operation, straight from integer arithmetic
    function automatic logic [63:0] ref_result(input logic op_i, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        if (!op_i) begin
            p = {32'd0, x} * {32'd0, y};
        end else if (y == 32'd0) begin
            p = {x, 32'hFFFF_FFFF};
        end else begin
            p = {x % y, x / y};
        end
        return p;
    endfunction

    task automatic check_result(input string tag, input logic op_i, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] e;
        e = ref_result(op_i, x, y);
        check_eq({tag, ".hi"},  {32'd0, hi}, {32'd0, e[63:32]});
        check_eq({tag, ".lo"},  {32'd0, lo}, {32'd0, e[31:0]});
        check_eq({tag, ".z"},   {63'd0, z},   {63'd0, (e == 64'd0)});
        check_eq({tag, ".n"},   {63'd0, n},   {63'd0, e[63]});
        check_eq({tag, ".dbz"}, {63'd0, dbz}, {63'd0, (op_i && y == 32'd0)});
    endtask

    // One operation; pulse_at > 0 re-asserts start with other operands in that busy cycle.
    task automatic run_op(input string tag, input logic op_i, input logic [31:0] x,
                          input logic [31:0] y, input int pulse_at);
        int   cyc;
        int   busy_cnt;
        logic seen;
        logic is_dbz;
        is_dbz = op_i && (y == 32'd0);
        @(negedge clock);
        start = 1'b1; op = op_i; a = x; b = y;
        cyc = 0; busy_cnt = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge clock); #1;
            cyc++;
            start = (cyc == pulse_at);
            op = $urandom_range(0, 1); a = $urandom; b = $urandom;
            if (busy) busy_cnt++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check_eq({tag, ".done_seen"}, {63'd0, seen}, 64'd1);
        check_eq({tag, ".latency"}, 64'(cyc), is_dbz ? 64'd1 : 64'd33);
        check_eq({tag, ".busy_cycles"}, 64'(busy_cnt), is_dbz ? 64'd0 : 64'd32);
        check_result(tag, op_i, x, y);
        @(posedge clock); #1;
        check_eq({tag, ".done_pulse"}, {63'd0, done}, 64'd0);
        check_eq({tag, ".hold_lo"}, {32'd0, lo}, {32'd0, ref_result(op_i, x, y) & 64'hFFFF_FFFF});
    endtask

    // Start held through the first DONE launches the second operation immediately.
    task automatic run_b2b(input logic op1, input logic [31:0] x1, input logic [31:0] y1,
                           input logic op2, input logic [31:0] x2, input logic [31:0] y2);
        int   cyc;
        logic seen;
        @(negedge clock);
        start = 1'b1; op = op1; a = x1; b = y1;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge clock); #1;
            cyc++;
            op = op2; a = x2; b = y2;
            if (done) seen = 1'b1;
        end
        check_eq("b2b1.latency", 64'(cyc), 64'd33);
        check_result("b2b1", op1, x1, y1);
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge clock); #1;
            cyc++;
            start = 1'b0;
            if (cyc == 1) check_eq("b2b2.busy_no_bubble", {63'd0, busy}, 64'd1);
            if (done) seen = 1'b1;
        end
        check_eq("b2b2.latency", 64'(cyc), 64'd33);
        check_result("b2b2", op2, x2, y2);
    endtask

    task automatic run_abort();
        int   cyc;
        logic seen;
        @(negedge clock);
        start = 1'b1; op = 1'b0; a = 32'h0001_2345; b = 32'h0000_0777;
        for (cyc = 0; cyc < 10; cyc++) begin
            @(posedge clock); #1;
            start = 1'b0;
        end
        check_eq("abort.busy_before", {63'd0, busy}, 64'd1);
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        check_eq("abort.busy", {63'd0, busy}, 64'd0);
        check_eq("abort.done", {63'd0, done}, 64'd0);
        check_eq("abort.hilo", {hi, lo}, 64'd0);
        check_eq("abort.flags", {61'd0, z, n, dbz}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (done || busy) seen = 1'b1;
        end
        check_eq("abort.no_done", {63'd0, seen}, 64'd0);
    endtask

    initial begin
        logic        rop;
        logic [31:0] ra;
        logic [31:0] rb;
        reset_n = 1'b0; start = 1'b0; op = 1'b0; a = 32'd0; b = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        check_eq("reset.busy", {63'd0, busy}, 64'd0);
        check_eq("reset.done", {63'd0, done}, 64'd0);
        check_eq("reset.hilo", {hi, lo}, 64'd0);
        check_eq("reset.flags", {61'd0, z, n, dbz}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        run_op("mul7x6",   1'b0, 32'd7,          32'd6,          0);
        run_op("mulmax",   1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  0);
        run_op("mulzero",  1'b0, 32'd0,          32'h0000_1234,  0);
        run_op("div100_7", 1'b1, 32'd100,        32'd7,          0);
        run_op("divmax_1", 1'b1, 32'hFFFF_FFFF,  32'd1,          0);
        run_op("div3_10",  1'b1, 32'd3,          32'd10,         0);
        run_op("dbz",      1'b1, 32'd5,          32'd0,          0);
        run_op("after_dbz", 1'b0, 32'd3,         32'd4,          0);
        run_op("midstart", 1'b0, 32'h0000_1234,  32'h0000_5678,  10);
        run_b2b(1'b0, 32'hDEAD_BEEF, 32'h0000_0100, 1'b1, 32'hCAFE_F00D, 32'h0000_0013);
        run_abort();

        for (int i = 0; i < 24; i++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 255));
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d", i), rop, ra, rb, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
